seq_detect_sched: RTL and testbench

//  Time-shares one serial "1101" pattern-detector datapath (overlapping, Mealy) among N_CH bit streams.

---
 rtl/seq_detect_sched.sv | 132 +++++++++++++
 tb/tb_seq_detect_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one overlapping Mealy "1101" detector shared round-robin
// among N_CH serial channels. Each channel's detector state and saturating
// match counter are kept in per-channel registers and swapped in on grant.
//
// Handshake: a channel's bit is consumed on the rising edge where
// req_valid[i] & req_ready[i] is high. req_valid must not depend on req_ready,
// and req_bit[i] is held stable while req_valid[i] is high and not yet granted.
module seq_detect_sched #(
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   req_valid,
   input  logic [N_CH-1:0]   req_bit,
   output logic [N_CH-1:0]   req_ready,
   input  logic [N_CH-1:0]   clear,
   output logic              match_valid,
   output logic [CH_W-1:0]   match_ch,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [CNT_W-1:0]  rd_count,
   output logic [2*N_CH-1:0] o_dbg_ctx
);

   // S0: nothing useful seen, S1: "1", S2: "11", S3: "110"
   typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} ctx_e;

   ctx_e             r_ctx [N_CH];
   logic [CNT_W-1:0] r_cnt [N_CH];
   logic [CH_W-1:0]  r_ptr;
   logic             r_match_valid;
   logic [CH_W-1:0]  r_match_ch;

   logic [N_CH-1:0]  w_elig;
   logic             w_any;
   logic [CH_W-1:0]  w_gnt;
   int               w_idx;
   logic             w_accept;
   logic             w_bit;
   ctx_e             w_cur;
   ctx_e             w_nxt;
   logic             w_hit;

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      w_elig = req_valid & ~clear;
      w_any  = 1'b0;
      w_gnt  = '0;
      w_idx  = 0;
      for (int k = 1; k <= N_CH; k++) begin
         w_idx = (int'(r_ptr) + k) % N_CH;
         if (!w_any && w_elig[w_idx]) begin
            w_any = 1'b1;
            w_gnt = CH_W'(w_idx);
         end
      end
   end

   // No grant is ever visible while reset is held.
   assign w_accept = w_any & ~rst;

   // One-hot grant vector.
   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready[w_gnt] = 1'b1;
   end

   // Shared detector next-state for the granted channel's context.
   always_comb begin
      w_bit = req_bit[w_gnt];
      w_cur = r_ctx[w_gnt];
      w_nxt = S0;
      w_hit = 1'b0;
      case (w_cur)
         S0: w_nxt = w_bit ? S1 : S0;
         S1: w_nxt = w_bit ? S2 : S0;
         S2: w_nxt = w_bit ? S2 : S3;
         S3: begin
            w_nxt = w_bit ? S1 : S0;
            w_hit = w_bit;
         end
         default: w_nxt = w_bit ? S1 : S0;
      endcase
   end

   // Context, counter, pointer and match registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            r_ctx[i] <= S0;
            r_cnt[i] <= '0;
         end
         r_ptr         <= CH_W'(N_CH - 1);
         r_match_valid <= 1'b0;
         r_match_ch    <= '0;
      end else begin
         r_match_valid <= w_accept & w_hit;
         if (w_accept) begin
            r_ptr        <= w_gnt;
            r_ctx[w_gnt] <= w_nxt;
            if (w_hit) begin
               r_match_ch <= w_gnt;
               if (r_cnt[w_gnt] != '1) r_cnt[w_gnt] <= r_cnt[w_gnt] + CNT_W'(1);
            end
         end
         // A cleared channel is never granted in the same cycle, so no conflict.
         for (int i = 0; i < N_CH; i++) begin
            if (clear[i]) begin
               r_ctx[i] <= S0;
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // Counter read port; out-of-range selects read as zero.
   always_comb begin
      rd_count = '0;
      if (int'(rd_ch) < N_CH) rd_count = r_cnt[rd_ch];
   end

   // Expose all channel contexts for observation.
   always_comb begin
      o_dbg_ctx = '0;
      for (int i = 0; i < N_CH; i++) o_dbg_ctx[2*i +: 2] = r_ctx[i];
   end

   assign match_valid = r_match_valid;
   assign match_ch    = r_match_ch;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios followed by random traffic,
// checked against a history-based model (last accepted bits per channel).
// Two instances share stimulus: CNT_W=8 and CNT_W=2 to exercise saturation.
module tb_seq_detect_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_valid = '0;
   logic [3:0] req_bit = '0;
   logic [3:0] clear = '0;
   logic [1:0] rd_ch = '0;

   logic [3:0] req_ready, req_ready_s;
   logic       match_valid, match_valid_s;
   logic [1:0] match_ch, match_ch_s;
   logic [7:0] rd_count;
   logic [1:0] rd_count_s;
   logic [7:0] dbg, dbg_s;

   int n_vec = 0;
   int n_err = 0;

   // model state
   int         m_ptr;
   int         m_len [4];
   logic [3:0] m_last [4];
   int         m_cnt [4];
   logic       m_mv;
   int         m_mch;

   logic [3:0] obs_ready;
   logic       obs_mv;
   int         pulses;

   // clock
   always #5 clk = ~clk;

   seq_detect_sched #(.N_CH(4), .CH_W(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit),
      .req_ready(req_ready), .clear(clear), .match_valid(match_valid),
      .match_ch(match_ch), .rd_ch(rd_ch), .rd_count(rd_count), .o_dbg_ctx(dbg)
   );

   seq_detect_sched #(.N_CH(4), .CH_W(2), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit),
      .req_ready(req_ready_s), .clear(clear), .match_valid(match_valid_s),
      .match_ch(match_ch_s), .rd_ch(rd_ch), .rd_count(rd_count_s), .o_dbg_ctx(dbg_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Expected detector context = longest suffix of history that is a prefix of "1101".
   function automatic int exp_ctx(input int ch);
      if (m_len[ch] >= 3 && m_last[ch][2:0] == 3'b110) return 3;
      if (m_len[ch] >= 2 && m_last[ch][1:0] == 2'b11) return 2;
      if (m_len[ch] >= 1 && m_last[ch][0]) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ptr = 3;
      m_mv  = 1'b0;
      m_mch = 0;
      for (int i = 0; i < 4; i++) begin
         m_len[i]  = 0;
         m_last[i] = '0;
         m_cnt[i]  = 0;
      end
   endtask

   // One cycle: drive at negedge, check grant, model the edge, check outputs.
   task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c, input int rd);
      logic [3:0] elig;
      logic [3:0] exp_rdy;
      int g;
      int idx;
      logic hit;
      req_valid = v;
      req_bit   = b;
      clear     = c;
      rd_ch     = 2'(rd);
      #1;
      elig = v & ~c;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (g < 0 && elig[idx]) g = idx;
      end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      obs_ready = req_ready;
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("ready_s", 32'(req_ready_s), 32'(exp_rdy));
      hit = 1'b0;
      if (g >= 0) begin
         m_last[g] = {m_last[g][2:0], b[g]};
         m_len[g]  = min_i(m_len[g] + 1, 4);
         hit = (m_len[g] >= 4) && (m_last[g] == 4'b1101);
         if (hit) begin
            m_cnt[g]++;
            m_mch = g;
         end
         m_ptr = g;
      end
      m_mv = hit;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) begin
            m_len[i]  = 0;
            m_last[i] = '0;
            m_cnt[i]  = 0;
         end
      end
      @(posedge clk);
      #1;
      obs_mv = match_valid;
      if (match_valid === 1'b1) pulses++;
      chk("match_valid", 32'(match_valid), 32'(m_mv));
      chk("match_valid_s", 32'(match_valid_s), 32'(m_mv));
      chk("match_ch", 32'(match_ch), 32'(m_mch));
      chk("match_ch_s", 32'(match_ch_s), 32'(m_mch));
      chk("rd_count", 32'(rd_count), 32'(min_i(m_cnt[rd], 255)));
      chk("rd_count_s", 32'(rd_count_s), 32'(min_i(m_cnt[rd], 3)));
      for (int i = 0; i < 4; i++) chk("ctx", 32'(dbg[2*i +: 2]), 32'(exp_ctx(i)));
      @(negedge clk);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
   task automatic do_reset();
      req_valid = 4'hf;
      clear     = '0;
      rd_ch     = '0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_match_valid", 32'(match_valid), 32'd0);
      chk("rst_match_ch", 32'(match_ch), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_ctx", 32'(dbg), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input int ch, input logic bit_v);
      step(4'(1 << ch), bit_v ? 4'(1 << ch) : 4'b0, 4'b0, ch);
   endtask

   initial begin
      logic [3:0] seq5;
      logic [12:0] pat;
      pulses = 0;
      model_reset();
      @(negedge clk);
      do_reset();

      // 1: ch0 1101101
      pulses = 0;
      send(0, 1); send(0, 1); send(0, 0); send(0, 1);
      chk("t1_pulse_bit4", 32'(obs_mv), 32'd1);
      send(0, 1); send(0, 0); send(0, 1);
      chk("t1_pulse_bit7", 32'(obs_mv), 32'd1);
      chk("t1_pulses", 32'(pulses), 32'd2);
      chk("t1_count", 32'(rd_count), 32'd2);

      // 2: all valid -> 0,1,2,3,0,1,2,3; then only ch2
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'hf, 4'($urandom_range(0, 15)), 4'b0, i % 4);
         chk("t2_order", 32'(obs_ready), 32'(1 << (i % 4)));
      end
      for (int i = 0; i < 4; i++) begin
         step(4'b0100, 4'($urandom_range(0, 15)), 4'b0, 2);
         chk("t2_only_ch2", 32'(obs_ready), 32'h4);
      end

      // 3: interleave ch0 "11", ch1 "01", ch0 "01"
      step(4'b0, 4'b0, 4'b0011, 0);
      pulses = 0;
      send(0, 1); send(0, 1); send(1, 0); send(1, 1); send(0, 0); send(0, 1);
      chk("t3_pulses", 32'(pulses), 32'd1);
      chk("t3_match_ch", 32'(match_ch), 32'd0);
      chk("t3_ch1_ctx", 32'(dbg[3:2]), 32'd1);

      // 4: ch3 "110", clear with valid, then 1
      step(4'b0, 4'b0, 4'b1000, 3);
      send(3, 1); send(3, 1); send(3, 0);
      step(4'b1000, 4'b1000, 4'b1000, 3);
      chk("t4_masked", 32'(obs_ready), 32'd0);
      send(3, 1);
      chk("t4_no_match", 32'(obs_mv), 32'd0);
      chk("t4_count", 32'(rd_count), 32'd0);

      // 5: ch1 "1101101101101": 4 pulses, small counter stops at 3
      step(4'b0, 4'b0, 4'b0010, 1);
      pat = 13'b1101101101101;
      pulses = 0;
      for (int i = 12; i >= 0; i--) send(1, pat[i]);
      chk("t5_pulses", 32'(pulses), 32'd4);
      chk("t5_count8", 32'(rd_count), 32'd4);
      chk("t5_count2", 32'(rd_count_s), 32'd3);

      // 6: reset mid-"110" on ch0/ch1 with a pulse pending
      seq5 = 4'b0;
      send(0, 1); send(0, 1); send(0, 0);
      send(1, 1); send(1, 1); send(1, 0);
      send(0, 1);
      chk("t6_pulse_before_rst", 32'(obs_mv), 32'd1);
      do_reset();
      step(4'b0011, 4'b0011, 4'b0, 0);
      chk("t6_first_grant", 32'(obs_ready), 32'h1);
      chk("t6_no_match0", 32'(obs_mv), 32'd0);
      send(1, 1);
      chk("t6_no_match1", 32'(obs_mv), 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         seq5 = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), seq5, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
